ex_stage: RTL and testbench

Execute stage of the 5-stage RV32I pipeline. It combines operand forwarding, ALU, and branch/jump resolution with the EX/MEM pipeline register. It consumes ID/EX outputs and drives the memory-stage inputs, including the address and write data for data memory. Branch resolution is combinational in the same cycle. Memory-stage fields are registered with stall and flush control.

---
 rtl/ex_stage.sv | 151 +++++++++++++++
 tb/tb_ex_stage.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU,
// branch/jump resolution, and the EX/MEM pipeline register.
// Branch resolution is combinational; memory-stage fields are registered.
module ex_stage (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EnM,
  input  logic        FlushM,
  input  logic        RegWriteE,
  input  logic        MemWriteE,
  input  logic        JumpE,
  input  logic        BranchE,
  input  logic        JalrE,
  input  logic        ALUSrcE,
  input  logic [1:0]  ResultSrcE,
  input  logic [3:0]  ALUControlE,
  input  logic [2:0]  Funct3E,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic [31:0] ImmExtE,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_LUI  = 4'b1010
  } aluOp_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwdSel_e;

  logic [31:0] srcA;
  logic [31:0] writeDataE;
  logic [31:0] srcB;
  logic [31:0] aluResultE;
  logic        branchCond;
  logic [4:0]  shamt;

  // Operand forwarding; select 11 behaves like 00 (register-file value).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    srcA = RD1E;
    case (ForwardAE)
      FWD_WB:  srcA = ResultW;
      FWD_MEM: srcA = ALUResultM;
      default: srcA = RD1E;
    endcase
    writeDataE = RD2E;
    case (ForwardBE)
      FWD_WB:  writeDataE = ResultW;
      FWD_MEM: writeDataE = ALUResultM;
      default: writeDataE = RD2E;
    endcase
  end

  assign srcB  = ALUSrcE ? ImmExtE : writeDataE;
  assign shamt = srcB[4:0];

  // ALU; unassigned operation codes produce zero.
  always_comb begin
    aluResultE = 32'h0;
    case (ALUControlE)
      ALU_ADD:  aluResultE = srcA + srcB;
      ALU_SUB:  aluResultE = srcA - srcB;
      ALU_AND:  aluResultE = srcA & srcB;
      ALU_OR:   aluResultE = srcA | srcB;
      ALU_XOR:  aluResultE = srcA ^ srcB;
      ALU_SLT:  aluResultE = {31'h0, $signed(srcA) < $signed(srcB)};
      ALU_SLTU: aluResultE = {31'h0, srcA < srcB};
      ALU_SLL:  aluResultE = srcA << shamt;
      ALU_SRL:  aluResultE = srcA >> shamt;
      ALU_SRA:  aluResultE = $unsigned($signed(srcA) >>> shamt);
      ALU_LUI:  aluResultE = srcB;
      default:  aluResultE = 32'h0;
    endcase
  end

  // Branch condition compares SrcA with the forwarded rs2 value, never the immediate.
  always_comb begin
    branchCond = 1'b0;
    case (Funct3E)
      3'b000:  branchCond = (srcA == writeDataE);
      3'b001:  branchCond = (srcA != writeDataE);
      3'b100:  branchCond = ($signed(srcA) <  $signed(writeDataE));
      3'b101:  branchCond = ($signed(srcA) >= $signed(writeDataE));
      3'b110:  branchCond = (srcA <  writeDataE);
      3'b111:  branchCond = (srcA >= writeDataE);
      default: branchCond = 1'b0;
    endcase
  end

  assign PCSrcE    = JumpE | (BranchE & branchCond);
  assign PCTargetE = JalrE ? ((srcA + ImmExtE) & ~32'h1) : (PCE + ImmExtE);

  // EX/MEM register: flush inserts a bubble and beats the load enable.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!RST_N) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      ALUResultM <= 32'h0;
      WriteDataM <= 32'h0;
      PCPlus4M   <= 32'h0;
      RdM        <= 5'h0;
    end else if (FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      ALUResultM <= 32'h0;
      WriteDataM <= 32'h0;
      PCPlus4M   <= 32'h0;
      RdM        <= 5'h0;
    end else if (EnM) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= aluResultE;
      WriteDataM <= writeDataE;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the execute stage.
module tb_ex_stage;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        EnM, FlushM;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, JalrE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  typedef struct packed {
    logic        regWrite;
    logic        memWrite;
    logic [1:0]  resultSrc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } mRegs_t;

  mRegs_t model;
  int     nAsserts = 0;
  int     nFails   = 0;

  ex_stage dut (
    .CLK(CLK), .RST_N(RST_N), .EnM(EnM), .FlushM(FlushM),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .JalrE(JalrE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RdE(RdE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] regVal);
    if (sel == 2'd1)      return ResultW;
    else if (sel == 2'd2) return model.alu;
    else                  return regVal;
  endfunction

  function automatic logic [31:0] aluRef(input int op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      0:  return a + b;
      1:  return a + (~b) + 1;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      6:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return a[31] ? ~((~a) >> sh) : (a >> sh);
      10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic condRef(input int f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      0: return a == b;
      1: return a != b;
      4: return int'(a) < int'(b);
      5: return !(int'(a) < int'(b));
      6: return longint'(a) < longint'(b);
      7: return !(longint'(a) < longint'(b));
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [32:0] combRef();
    logic [31:0] a, rs2, tgt;
    logic        take;
    a    = fwd(ForwardAE, RD1E);
    rs2  = fwd(ForwardBE, RD2E);
    take = JumpE | (BranchE & condRef(int'(Funct3E), a, rs2));
    tgt  = JalrE ? ((a + ImmExtE) & 32'hFFFF_FFFE) : (PCE + ImmExtE);
    return {take, tgt};
  endfunction

  function automatic mRegs_t dutM();
    return {RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M};
  endfunction

  // Advance one clock edge and update the model with the inputs the DUT saw.
  task automatic tick();
    logic [31:0] a, wd, b;
    @(posedge CLK);
    a  = fwd(ForwardAE, RD1E);
    wd = fwd(ForwardBE, RD2E);
    b  = ALUSrcE ? ImmExtE : wd;
    if (!RST_N || FlushM) model = '0;
    else if (EnM) begin
      model.regWrite  = RegWriteE;
      model.memWrite  = MemWriteE;
      model.resultSrc = ResultSrcE;
      model.alu       = aluRef(int'(ALUControlE), a, b);
      model.wd        = wd;
      model.rd        = RdE;
      model.pc4       = PCPlus4E;
    end
    #1;
  endtask

  task automatic clear_inputs();
    EnM = 1; FlushM = 0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
    JalrE = 0; ALUSrcE = 0; ResultSrcE = 0; ALUControlE = 0; Funct3E = 0;
    RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCPlus4E = 0; RdE = 0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    RST_N = 0;
    model = '0;
    #2;
    nAsserts++;
    if (dutM() !== mRegs_t'(0)) begin
      nFails++; $display("FAIL reset_initial: got %h expected 0", dutM());
    end
    @(negedge CLK);
    RST_N = 1;
    tick();
    // Load nonzero state, then reset mid-cycle with no clock edge.
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2; RD1E = 32'h55; RD2E = 32'h66;
    RdE = 9; PCPlus4E = 32'h44; ALUControlE = 0;
    tick();
    nAsserts++;
    if (dutM() !== model || model == mRegs_t'(0)) begin
      nFails++; $display("FAIL reset_preload: got %h expected %h", dutM(), model);
    end
    #2;
    RST_N = 0;
    model = '0;
    #1;
    nAsserts++;
    if (dutM() !== mRegs_t'(0)) begin
      nFails++; $display("FAIL reset_async: got %h expected 0", dutM());
    end
    clear_inputs();
    @(negedge CLK);
    RST_N = 1;
    tick();
  endtask

  task automatic test_alu();
    clear_inputs();
    RD1E = 32'hFFFF_FFF0; ImmExtE = 32'h20; ALUSrcE = 1; ALUControlE = 4'b0000;
    RegWriteE = 1; RdE = 5;
    tick();
    nAsserts++;
    if (ALUResultM !== 32'h10 || RdM !== 5'd5 || RegWriteM !== 1'b1) begin
      nFails++; $display("FAIL alu_add: got alu=%h rd=%0d rw=%b expected alu=10 rd=5 rw=1",
                         ALUResultM, RdM, RegWriteM);
    end
    RD1E = 32'h8000_0000; ImmExtE = 32'd4; ALUControlE = 4'b1001;
    tick();
    nAsserts++;
    if (ALUResultM !== 32'hF800_0000) begin
      nFails++; $display("FAIL alu_sra: got %h expected f8000000", ALUResultM);
    end
    RD1E = 32'd1; RD2E = 32'hFFFF_FFFF; ALUSrcE = 0; ALUControlE = 4'b0110;
    tick();
    nAsserts++;
    if (ALUResultM !== 32'h1) begin
      nFails++; $display("FAIL alu_sltu: got %h expected 1", ALUResultM);
    end
    ALUControlE = 4'b0101;
    tick();
    nAsserts++;
    if (ALUResultM !== 32'h0) begin
      nFails++; $display("FAIL alu_slt: got %h expected 0", ALUResultM);
    end
    ALUControlE = 4'b1111;
    tick();
    nAsserts++;
    if (ALUResultM !== 32'h0) begin
      nFails++; $display("FAIL alu_undef: got %h expected 0", ALUResultM);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RD1E = 32'd3; ImmExtE = 32'd4; ALUSrcE = 1;
    tick();
    ForwardAE = 2'b10; RD1E = 32'd0; ImmExtE = 32'd1;
    tick();
    nAsserts++;
    if (ALUResultM !== 32'h8) begin
      nFails++; $display("FAIL fwd_mem: got %h expected 8", ALUResultM);
    end
    ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'hAB; MemWriteE = 1;
    RD2E = 32'h1234;
    tick();
    nAsserts++;
    if (WriteDataM !== 32'hAB || MemWriteM !== 1'b1) begin
      nFails++; $display("FAIL fwd_wb: got wd=%h mw=%b expected wd=ab mw=1", WriteDataM, MemWriteM);
    end
    ForwardAE = 2'b11; ForwardBE = 2'b11; RD1E = 32'h30; RD2E = 32'h77; ImmExtE = 32'h5;
    tick();
    nAsserts++;
    if (ALUResultM !== 32'h35 || WriteDataM !== 32'h77) begin
      nFails++; $display("FAIL fwd_11: got alu=%h wd=%h expected alu=35 wd=77", ALUResultM, WriteDataM);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] acc;
    clear_inputs();
    RD1E = 32'd100; ImmExtE = 32'd7; ALUSrcE = 1;
    tick();
    acc = 32'd107;
    ForwardAE = 2'b10; RD1E = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc = acc + 32'd7;
      nAsserts++;
      if (ALUResultM !== acc) begin
        nFails++; $display("FAIL chain_%0d: got %h expected %h", i, ALUResultM, acc);
      end
    end
  endtask

  task automatic test_branch();
    logic [32:0] exp;
    clear_inputs();
    PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8; BranchE = 1; Funct3E = 3'b100;
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd1; ALUSrcE = 1;
    #1;
    nAsserts++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'hF8) begin
      nFails++; $display("FAIL br_blt: got src=%b tgt=%h expected src=1 tgt=f8", PCSrcE, PCTargetE);
    end
    Funct3E = 3'b110;
    #1;
    nAsserts++;
    if (PCSrcE !== 1'b0) begin
      nFails++; $display("FAIL br_bltu: got %b expected 0", PCSrcE);
    end
    // Branch compares against rs2, not the immediate selected for SrcB.
    Funct3E = 3'b000; RD2E = 32'hFFFF_FFFF; ImmExtE = 32'h8;
    #1;
    nAsserts++;
    if (PCSrcE !== 1'b1) begin
      nFails++; $display("FAIL br_beq_rs2: got %b expected 1", PCSrcE);
    end
    Funct3E = 3'b010;
    #1;
    nAsserts++;
    if (PCSrcE !== 1'b0) begin
      nFails++; $display("FAIL br_f3_010: got %b expected 0", PCSrcE);
    end
    // Stall and flush must not gate the redirect.
    Funct3E = 3'b000; EnM = 0; FlushM = 1;
    exp = combRef();
    #1;
    nAsserts++;
    if ({PCSrcE, PCTargetE} !== exp) begin
      nFails++; $display("FAIL br_ungated: got %h expected %h", {PCSrcE, PCTargetE}, exp);
    end
    tick();
  endtask

  task automatic test_jalr();
    clear_inputs();
    JumpE = 1; JalrE = 1; RD1E = 32'h1003; ImmExtE = 32'd2; PCE = 32'h500;
    PCPlus4E = 32'h504; RegWriteE = 1; RdE = 1; ALUSrcE = 1;
    #1;
    nAsserts++;
    if (PCSrcE !== 1'b1 || PCTargetE !== 32'h1004) begin
      nFails++; $display("FAIL jalr_target: got src=%b tgt=%h expected src=1 tgt=1004", PCSrcE, PCTargetE);
    end
    tick();
    nAsserts++;
    if (PCPlus4M !== 32'h504) begin
      nFails++; $display("FAIL jalr_pc4: got %h expected 504", PCPlus4M);
    end
  endtask

  task automatic test_stall_flush();
    mRegs_t held;
    clear_inputs();
    RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD1E = 32'h40; ImmExtE = 32'h2;
    ALUSrcE = 1; RD2E = 32'h99; RdE = 12; PCPlus4E = 32'h80;
    tick();
    held = {1'b1, 1'b1, 2'd1, 32'h42, 32'h99, 5'd12, 32'h80};
    EnM = 0;
    for (int i = 0; i < 3; i++) begin
      RD1E = $urandom; RD2E = $urandom; ImmExtE = $urandom; RdE = 5'($urandom);
      PCPlus4E = $urandom; RegWriteE = 1'($urandom); ResultSrcE = 2'($urandom);
      ForwardAE = 2'b10; JalrE = 1; ImmExtE = 32'h10;
      #1;
      nAsserts++;
      if (PCTargetE !== 32'h52) begin
        nFails++; $display("FAIL stall_fwd_%0d: got %h expected 52", i, PCTargetE);
      end
      tick();
      nAsserts++;
      if (dutM() !== held) begin
        nFails++; $display("FAIL stall_hold_%0d: got %h expected %h", i, dutM(), held);
      end
    end
    clear_inputs();
    FlushM = 1; EnM = 1; RegWriteE = 1; MemWriteE = 1; RdE = 7; RD1E = 32'h3;
    tick();
    nAsserts++;
    if (dutM() !== mRegs_t'(0)) begin
      nFails++; $display("FAIL flush: got %h expected 0", dutM());
    end
  endtask

  task automatic test_random();
    logic [32:0] exp;
    for (int i = 0; i < 300; i++) begin
      EnM = ($urandom_range(0, 9) < 8); FlushM = ($urandom_range(0, 9) == 0);
      RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
      BranchE = 1'($urandom); JalrE = 1'($urandom); ALUSrcE = 1'($urandom);
      ResultSrcE = 2'($urandom); ALUControlE = 4'($urandom); Funct3E = 3'($urandom);
      RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
      ImmExtE = $urandom; PCE = $urandom; PCPlus4E = $urandom; RdE = 5'($urandom);
      ForwardAE = 2'($urandom); ForwardBE = 2'($urandom); ResultW = $urandom;
      exp = combRef();
      #1;
      nAsserts++;
      if ({PCSrcE, PCTargetE} !== exp) begin
        nFails++; $display("FAIL rand_comb_%0d: got %h expected %h", i, {PCSrcE, PCTargetE}, exp);
      end
      tick();
      nAsserts++;
      if (dutM() !== model) begin
        nFails++; $display("FAIL rand_m_%0d: got %h expected %h", i, dutM(), model);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_forwarding();
    test_back_to_back();
    test_branch();
    test_jalr();
    test_stall_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
